// File: rtl/led_pattern_pkg.sv
// Shared definitions for the LED pattern engine.
//   - Animation mode encodings (Mode input values).
//   - Ping-pong direction encoding.
//   - clog2_min1: counter width helper, never returns less than 1 bit.
package led_pattern_pkg;

    localparam logic [1:0] MODE_HOLD     = 2'b00;
    localparam logic [1:0] MODE_ROR      = 2'b01;
    localparam logic [1:0] MODE_ROL      = 2'b10;
    localparam logic [1:0] MODE_PINGPONG = 2'b11;

    typedef enum logic {
        DIR_RIGHT = 1'b0,
        DIR_LEFT  = 1'b1
    } dir_e;

    // Bits needed to hold values 0..value-1, with a floor of one bit so
    // degenerate counters (value <= 2) still have a legal vector width.
    function automatic int clog2_min1(input int unsigned value);
        int result;
        result = 1;
        for (int i = 1; i < 32; i++) begin
            if ((64'(1) << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/switch_debounce.sv
// One-bit switch conditioner: 2-FF synchroniser followed by a debounce
// counter. The stable output only changes after DEBOUNCE_CYCLES consecutive
// synchronised samples disagree with it.
// Ports:
//   clk_i     system clock
//   rst_ni    asynchronous active-low reset
//   sw_i      raw asynchronous switch, active-low
//   stable_o  debounced level (1 = released), resets to released
module switch_debounce
    import led_pattern_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sw_i,
    output logic stable_o
);

    localparam int               CNT_W    = clog2_min1(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta_q;
    logic             sync_q;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Synchroniser flops reset to released so no phantom press appears
    // after reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q   <= 1'b1;
            sync_q   <= 1'b1;
            stable_q <= 1'b1;
            cnt_q    <= '0;
        end else begin
            meta_q   <= sw_i;
            sync_q   <= meta_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    // Any sample agreeing with the stable level restarts the count, so only
    // an unbroken run of DEBOUNCE_CYCLES differing samples is accepted.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/led_pattern_engine.sv
// N-LED animation engine driven from N active-low push buttons.
// A prescaler produces one tick every TICK_DIV cycles; on each tick the
// one-hot pattern is reloaded from the lowest pressed button or advanced
// according to the selected mode (hold / rotate right / rotate left /
// ping-pong). Step pulses for one cycle whenever the pattern updates.
// Optional feature macro: LED_PWM_EN adds a PWM_BITS brightness dimmer;
// LED and Step then lag the pattern by one registered cycle.
// Ports:
//   clk_i         system clock, rising edge
//   rst_ni        asynchronous active-low reset
//   switch_i      raw push buttons, active-low, asynchronous
//   mode_i        00 hold, 01 rotate right, 10 rotate left, 11 ping-pong
//   brightness_i  PWM duty select (only used with LED_PWM_EN)
//   led_o         LED drive, active-high
//   step_o        one-cycle pulse when the displayed pattern updates
module led_pattern_engine
    import led_pattern_pkg::*;
#(
    parameter int NUM_LEDS        = 8,
    parameter int TICK_DIV        = 33554432,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int PWM_BITS        = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NUM_LEDS-1:0] switch_i,
    input  logic [1:0]          mode_i,
    input  logic [PWM_BITS-1:0] brightness_i,
    output logic [NUM_LEDS-1:0] led_o,
    output logic                step_o
);

    localparam int                TICK_W    = clog2_min1(TICK_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    logic [NUM_LEDS-1:0] stable;
    logic [NUM_LEDS-1:0] pressed;
    logic [TICK_W-1:0]   presc_q, presc_d;
    logic                tick;
    logic [NUM_LEDS-1:0] pat_q, pat_d;
    dir_e                dir_q, dir_d;
    logic                step_q;

    for (genvar g = 0; g < NUM_LEDS; g++) begin : g_sw
        switch_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .sw_i     (switch_i[g]),
            .stable_o (stable[g])
        );
    end

    assign pressed = ~stable;

    // Prescaler
    assign tick    = (presc_q == TICK_LAST);
    assign presc_d = tick ? '0 : presc_q + TICK_W'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presc_q <= '0;
            pat_q   <= NUM_LEDS'(1);
            dir_q   <= DIR_RIGHT;
            step_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            pat_q   <= pat_d;
            dir_q   <= dir_d;
            step_q  <= tick;
        end
    end

    // Pattern / direction next state. Rotations are built from shifts so
    // that NUM_LEDS = 1 needs no zero-width slices.
    always_comb begin
        pat_d = pat_q;
        dir_d = dir_q;
        if (tick) begin
            if (|pressed) begin
                // Isolate lowest set bit: lowest pressed index wins.
                pat_d = pressed & (~pressed + NUM_LEDS'(1));
            end else begin
                case (mode_i)
                    MODE_HOLD: pat_d = pat_q;
                    MODE_ROR:  pat_d = (pat_q >> 1) | (pat_q << (NUM_LEDS - 1));
                    MODE_ROL:  pat_d = (pat_q << 1) | (pat_q >> (NUM_LEDS - 1));
                    default: begin // MODE_PINGPONG
                        if (dir_q == DIR_RIGHT) begin
                            if (pat_q[0]) begin
                                dir_d = DIR_LEFT;
                                pat_d = pat_q << 1;
                            end else begin
                                pat_d = pat_q >> 1;
                            end
                        end else begin
                            if (pat_q[NUM_LEDS-1]) begin
                                dir_d = DIR_RIGHT;
                                pat_d = pat_q >> 1;
                            end else begin
                                pat_d = pat_q << 1;
                            end
                        end
                    end
                endcase
            end
            // A single LED has nowhere to move; keep it lit in every mode.
            if (NUM_LEDS == 1) begin
                pat_d = '1;
            end
        end
    end

`ifdef LED_PWM_EN
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic                pwm_on;
    logic [NUM_LEDS-1:0] led_q, led_d;
    logic                step_dly_q;

    // All-ones brightness must be fully on, which the plain compare
    // against a wrapping counter cannot express.
    assign pwm_on = (pwm_cnt_q < brightness_i) || (&brightness_i);
    assign led_d  = pat_q & {NUM_LEDS{pwm_on}};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pwm_cnt_q  <= '0;
            led_q      <= NUM_LEDS'(1);
            step_dly_q <= 1'b0;
        end else begin
            pwm_cnt_q  <= pwm_cnt_q + PWM_BITS'(1);
            led_q      <= led_d;
            step_dly_q <= step_q;
        end
    end

    assign led_o  = led_q;
    assign step_o = step_dly_q;
`else
    logic unused_brightness;
    assign unused_brightness = ^brightness_i;

    assign led_o  = pat_q;
    assign step_o = step_q;
`endif

endmodule

// File: tb/tb_led_pattern_engine.sv
// Directed bench for led_pattern_engine with NUM_LEDS=8, TICK_DIV=4,
// DEBOUNCE_CYCLES=3. A table of {mode, switches, expected LED, expected
// Step spacing} records drives the main animation; hand-written sequences
// cover debounce, simultaneous presses, mid-prescale reset and (with
// LED_PWM_EN) dimming.
module tb_led_pattern_engine;

`ifdef LED_PWM_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] sw = 8'hFF;
    logic [1:0] mode = 2'b01;
    logic [3:0] bright = 4'hF;
    logic [7:0] led;
    logic       step;

    int total = 0;
    int bad   = 0;

    led_pattern_engine #(
        .NUM_LEDS        (8),
        .TICK_DIV        (4),
        .DEBOUNCE_CYCLES (3),
        .PWM_BITS        (4)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .switch_i     (sw),
        .mode_i       (mode),
        .brightness_i (bright),
        .led_o        (led),
        .step_o       (step)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] mode;
        logic [7:0] sw;
        logic [7:0] exp_led;
        int         exp_gap;
    } vec_t;

    vec_t vecs[23];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Waits for the next Step pulse, sampled on falling edges; returns the
    // number of cycles waited.
    task automatic wait_step(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!step && cyc < 16);
        if (!step) begin
            total++;
            bad++;
            $display("FAIL step_timeout: no Step within %0d cycles", cyc);
        end
    endtask

    task automatic step_expect(input string name, input logic [7:0] exp_led);
        int cyc;
        wait_step(cyc);
        check(name, int'(led), int'(exp_led));
    endtask

    initial begin
        int cyc;
        int on_cnt;

        vecs[0]  = '{2'b01, 8'hFF, 8'h80, 4 + LAT};
        vecs[1]  = '{2'b01, 8'hFF, 8'h40, 4};
        vecs[2]  = '{2'b01, 8'hFF, 8'h20, 4};
        vecs[3]  = '{2'b11, 8'hFF, 8'h10, 4};
        vecs[4]  = '{2'b11, 8'hFF, 8'h08, 4};
        vecs[5]  = '{2'b11, 8'hFF, 8'h04, 4};
        vecs[6]  = '{2'b11, 8'hFF, 8'h02, 4};
        vecs[7]  = '{2'b11, 8'hFF, 8'h01, 4};
        vecs[8]  = '{2'b11, 8'hFF, 8'h02, 4};
        vecs[9]  = '{2'b11, 8'hFF, 8'h04, 4};
        vecs[10] = '{2'b11, 8'hFF, 8'h08, 4};
        vecs[11] = '{2'b11, 8'hFF, 8'h10, 4};
        vecs[12] = '{2'b11, 8'hFF, 8'h20, 4};
        vecs[13] = '{2'b11, 8'hFF, 8'h40, 4};
        vecs[14] = '{2'b11, 8'hFF, 8'h80, 4};
        vecs[15] = '{2'b11, 8'hFF, 8'h40, 4};
        vecs[16] = '{2'b11, 8'hFF, 8'h20, 4};
        vecs[17] = '{2'b10, 8'hFF, 8'h40, 4};
        vecs[18] = '{2'b10, 8'hFF, 8'h80, 4};
        vecs[19] = '{2'b10, 8'hFF, 8'h01, 4};
        vecs[20] = '{2'b00, 8'hFF, 8'h01, 4};
        vecs[21] = '{2'b00, 8'hFF, 8'h01, 4};
        vecs[22] = '{2'b01, 8'hFF, 8'h80, 4};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_led", int'(led), 8'h01);
        check("reset_step", int'(step), 0);
        rst_n = 1'b1;

        // Table: each record is applied right after a Step, so its mode is
        // sampled on the following tick.
        for (int i = 0; i < 23; i++) begin
            mode = vecs[i].mode;
            sw   = vecs[i].sw;
            wait_step(cyc);
            check($sformatf("vec%0d_led", i), int'(led), int'(vecs[i].exp_led));
            check($sformatf("vec%0d_gap", i), cyc, vecs[i].exp_gap);
        end

        // Switch[5] held: accepted after the tick already in flight, held
        // through further ticks, rotation resumes once release is accepted.
        sw = 8'hDF;
        step_expect("sw5_pre", 8'h40);
        step_expect("sw5_acc", 8'h20);
        step_expect("sw5_hold", 8'h20);
        sw = 8'hFF;
        step_expect("sw5_rel0", 8'h20);
        step_expect("sw5_rel1", 8'h10);
        step_expect("sw5_rel2", 8'h08);

        // Switch[2] glitch of two cycles must never be accepted.
        sw = 8'hFB;
        repeat (2) @(negedge clk);
        sw = 8'hFF;
        step_expect("glitch_a", 8'h04);
        step_expect("glitch_b", 8'h02);

        // Switch[6] and Switch[3] together: lowest index wins.
        sw = 8'hB7;
        step_expect("dual_pre", 8'h01);
        step_expect("dual_acc", 8'h08);
        step_expect("dual_hold", 8'h08);

        // Swap to Switch[4], then hold mode keeps 10 after release.
        sw = 8'hEF;
        step_expect("sw4_pre", 8'h08);
        step_expect("sw4_acc", 8'h10);
        mode = 2'b00;
        sw   = 8'hFF;
        step_expect("hold_a", 8'h10);
        step_expect("hold_b", 8'h10);
        step_expect("hold_c", 8'h10);

        // Asynchronous reset mid-prescale.
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_led", int'(led), 8'h01);
        check("async_rst_step", int'(step), 0);
        @(negedge clk);
        rst_n = 1'b1;
        mode  = 2'b01;
        wait_step(cyc);
        check("post_rst_gap", cyc, 4 + LAT);
        check("post_rst_led", int'(led), 8'h80);

`ifdef LED_PWM_EN
        mode = 2'b00;
        bright = 4'h4;
        repeat (3) @(negedge clk);
        on_cnt = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (led != 8'h00) on_cnt++;
        end
        check("pwm_b4_on", on_cnt, 4);
        bright = 4'hF;
        repeat (3) @(negedge clk);
        on_cnt = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (led == 8'h80) on_cnt++;
        end
        check("pwm_b15_on", on_cnt, 16);
        bright = 4'h0;
        repeat (3) @(negedge clk);
        on_cnt = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (led != 8'h00) on_cnt++;
        end
        check("pwm_b0_on", on_cnt, 0);
`else
        on_cnt = 0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
